md_unit: RTL

Multiply/divide unit for the pipelined MIPS core, in the EX stage directly downstream of the general register file. It consumes the rs/rt read data (forwarded) together with a decoded operation code. It performs mult/multu/div/divu over a fixed multi-cycle latency and holds the architectural HI/LO registers. It also services mthi/mtlo writes and exposes HI/LO for mfhi/mflo.

---
 rtl/md_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding the HI/LO registers.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start, op    request strobe and operation (1 mult, 2 multu,
//                3 div, 4 divu, 5 mthi, 6 mtlo, 0/7 none)
//   a, b         operands (rs / rt data)
//   busy         arithmetic operation in flight
//   hi, lo       architectural HI/LO registers
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]    state;
  logic [CW-1:0] count;
  logic [31:0]   pendHi;
  logic [31:0]   pendLo;
  logic          pendWr;

  logic isMul;
  logic isDiv;
  logic sx;

  assign isMul = (op == OP_MULT) || (op == OP_MULTU);
  assign isDiv = (op == OP_DIV)  || (op == OP_DIVU);
  assign sx    = (op == OP_MULT) || (op == OP_DIV);

  // One 64-bit multiplier serves both flavours: the low 64 bits
  // of a product of sign-extended operands equal the signed product.
  logic [63:0] extA;
  logic [63:0] extB;
  logic [63:0] prod;

  assign extA = {{32{sx & a[31]}}, a};
  assign extB = {{32{sx & b[31]}}, b};
  assign prod = extA * extB;

  // Divide on magnitudes, then fix signs: quotient truncates toward
  // zero, remainder follows the dividend. 0x80000000 / -1 falls out
  // as 0x80000000 rem 0 without special casing.
  logic        aNeg;
  logic        bNeg;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [31:0] dvsr;
  logic [31:0] uQ;
  logic [31:0] uR;
  logic [31:0] sQ;
  logic [31:0] sR;

  assign aNeg = sx & a[31];
  assign bNeg = sx & b[31];
  assign absA = aNeg ? (32'd0 - a) : a;
  assign absB = bNeg ? (32'd0 - b) : b;
  assign dvsr = (absB == 32'd0) ? 32'd1 : absB;
  assign uQ   = absA / dvsr;
  assign uR   = absA % dvsr;
  assign sQ   = (aNeg ^ bNeg) ? (32'd0 - uQ) : uQ;
  assign sR   = aNeg ? (32'd0 - uR) : uR;

  logic [31:0]   resHi;
  logic [31:0]   resLo;
  logic          resWr;
  logic [CW-1:0] resCyc;

  always_comb begin
    resHi  = 32'd0;
    resLo  = 32'd0;
    resWr  = 1'b0;
    resCyc = '0;
    unique case (1'b1)
      isMul: begin
        resHi  = prod[63:32];
        resLo  = prod[31:0];
        resWr  = 1'b1;
        resCyc = MC;
      end
      isDiv: begin
        resHi  = sR;
        resLo  = sQ;
        resWr  = (b != 32'd0);
        resCyc = DC;
      end
      default: ;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      pendHi <= 32'd0;
      pendLo <= 32'd0;
      pendWr <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (isMul || isDiv) begin
              pendHi <= resHi;
              pendLo <= resLo;
              pendWr <= resWr;
              count  <= resCyc;
              state  <= RUN;
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        default: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            if (pendWr) begin
              hi <= pendHi;
              lo <= pendLo;
            end
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
